// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    function automatic logic is_signed_a(muldiv_op_e op);
        return op inside {MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic is_signed_b(muldiv_op_e op);
        return op inside {MULH, DIV, REM};
    endfunction

    function automatic logic is_div(muldiv_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply on {acc,mplier} or
// restoring-division trial subtract on {rem,quot}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           fits;

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        sum    = lo_in[0] ? ({1'b0, hi_in} + {1'b0, operand}) : {1'b0, hi_in};
        rem_sh = {hi_in, lo_in[WIDTH-1]};
        diff   = rem_sh - {1'b0, operand};
        // rem < divisor before the shift, so the borrow bit alone decides the trial.
        fits   = ~diff[WIDTH];
        if (is_div) begin
            hi_out = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], fits};
        end else begin
            hi_out = sum[WIDTH:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide with valid/ready handshake on both sides.
// Define MULDIV_FAST_MUL_EN to route the four MUL ops through a single-cycle multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int              CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    muldiv_op_e       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;

    muldiv_op_e         op_in;
    logic               accept, a_neg, b_neg, div_zero, div_ovf, quot_in, short_path, op_is_div;
    logic [WIDTH-1:0]   a_abs, b_abs, quick_res, step_hi, step_lo, div_mag, div_signed;
    logic [2*WIDTH-1:0] prod_mag, prod_signed;

    assign op_in     = muldiv_op_e'(op);
    assign accept    = in_valid & in_ready & ~flush;
    assign a_neg     = is_signed_a(op_in) & srca[WIDTH-1];
    assign b_neg     = is_signed_b(op_in) & srcb[WIDTH-1];
    assign a_abs     = a_neg ? -srca : srca;
    assign b_abs     = b_neg ? -srcb : srcb;
    assign quot_in   = op_in inside {DIV, DIVU};
    assign div_zero  = is_div(op_in) && (srcb == '0);
    assign div_ovf   = is_div(op_in) && is_signed_b(op_in) && (srca == MOST_NEG) && (srcb == '1);
    assign op_is_div = is_div(op_q);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{WIDTH{a_neg}}, srca};
    assign fast_b    = {{WIDTH{b_neg}}, srcb};
    assign fast_prod = fast_a * fast_b;
`endif

    // Ops that finish straight from IDLE: divide corner cases (and fast multiply).
    always_comb begin
        short_path = div_zero | div_ovf;
        quick_res  = '0;
        if (div_zero) begin
            quick_res = quot_in ? '1 : srca;
        end else if (div_ovf) begin
            quick_res = quot_in ? srca : '0;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!is_div(op_in)) begin
            short_path = 1'b1;
            quick_res  = (op_in == MUL) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
        end
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_is_div),
        .hi_in   (hi_q),
        .lo_in   (lo_q),
        .operand (opnd_q),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    assign prod_mag    = {hi_q, lo_q};
    assign prod_signed = neg_q ? -prod_mag : prod_mag;
    assign div_mag     = (op_q inside {DIV, DIVU}) ? lo_q : hi_q;
    assign div_signed  = neg_q ? -div_mag : div_mag;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = short_path ? DONE : CALC;
            CALC: if (cnt_q == LAST_STEP) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush && state_q != IDLE) state_d = IDLE;
    end

    // Datapath: operand capture, iteration and sign fix-up.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: if (accept) begin
                op_d   = op_in;
                neg_d  = (op_in inside {REM, REMU}) ? a_neg : (a_neg ^ b_neg);
                cnt_d  = '0;
                hi_d   = '0;
                lo_d   = a_abs;
                opnd_d = b_abs;
                if (short_path) result_d = quick_res;
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
            end
            FIX: if (!flush) begin
                if (op_is_div)          result_d = div_signed;
                else if (op_q == MUL)   result_d = prod_signed[WIDTH-1:0];
                else                    result_d = prod_signed[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // NOTE: operand registers are always loaded on accept before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        neg_q  <= neg_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        opnd_q <= opnd_d;
    end

    // Handshake outputs.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    assign result = result_q;
    assign zero   = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32); honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Waits for in_ready (bounded), presents one op for a single accepting edge.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o; srca = a; srcb = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the cycle right after the accepting edge as 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic watch_no_valid(input string name, input int cycles);
        logic seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [22];
        int          lat;
        logic [31:0] r;
        logic        z;
        logic [31:0] prev;

        vecs = '{
            '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT},
            '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT},
            '{MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT},
            '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT},
            '{MUL,    32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT},
            '{MULH,   32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, MUL_LAT},
            '{MUL,    32'd0,        32'd5,        32'd0,        MUL_LAT},
            '{MULHU,  32'h00010000, 32'h00010000, 32'd1,        MUL_LAT},
            '{DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, DIV_LAT},
            '{REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, DIV_LAT},
            '{DIVU,   32'd20,       32'd3,        32'd6,        DIV_LAT},
            '{REMU,   32'd20,       32'd3,        32'd2,        DIV_LAT},
            '{DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, DIV_LAT},
            '{REM,    32'd20,       32'hFFFFFFFD, 32'd2,        DIV_LAT},
            '{DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1},
            '{REMU,   32'd5,        32'd0,        32'd5,        1},
            '{DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1},
            '{REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1},
            '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
            '{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1},
            '{DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        DIV_LAT},
            '{REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT}
        };

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset in_ready",  {31'd0, in_ready},  32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result",    result,             32'd0);
        check("reset zero",      {31'd0, zero},      32'd1);
        check("reset busy",      {31'd0, busy},      32'd0);

        // Table-driven ops
        for (int i = 0; i < 22; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(lat);
            r = result;
            z = zero;
            consume();
            check($sformatf("vec%0d result", i),  r,               vecs[i].exp);
            check($sformatf("vec%0d zero", i),    {31'd0, z},      {31'd0, vecs[i].exp == 32'd0});
            check($sformatf("vec%0d latency", i), 32'(lat),        32'(vecs[i].lat));
        end

        // Back-pressure: result held and no acceptance while out_ready is low
        start_op(DIVU, 32'd100, 32'd7);
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'(DIV_LAT));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp hold%0d result", k),    result,               32'd14);
            check($sformatf("bp hold%0d in_ready", k),  {31'd0, in_ready},    32'd0);
            check($sformatf("bp hold%0d out_valid", k), {31'd0, out_valid},   32'd1);
            @(posedge clk); #1;
        end
        // New request presented during the consuming edge must wait one cycle
        op = DIVU; srca = 32'd5; srcb = 32'd0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consume no same-cycle accept", {31'd0, out_valid}, 32'd0);
        check("consume in_ready",             {31'd0, in_ready},  32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("accept after consume valid", {31'd0, out_valid}, 32'd1);
        check("accept after consume result", result,            32'hFFFFFFFF);
        consume();

        // flush in IDLE blocks acceptance
        op = DIVU; srca = 32'd9; srcb = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("idle flush in_ready",  {31'd0, in_ready},  32'd1);
        check("idle flush out_valid", {31'd0, out_valid}, 32'd0);

        // flush at step 10 of a DIV
        prev = result;
        start_op(DIV, 32'hFFFFFFEC, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush to idle",       {31'd0, in_ready}, 32'd1);
        check("flush result kept",   result,            prev);
        watch_no_valid("flush no out_valid", 40);
        start_op(DIVU, 32'd20, 32'd3);
        wait_valid(lat);
        check("post-flush result",  result,   32'd6);
        check("post-flush latency", 32'(lat), 32'(DIV_LAT));
        consume();

        // Reset mid-operation discards the op
        start_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("midreset in_ready", {31'd0, in_ready}, 32'd1);
        check("midreset result",   result,            32'd0);
        check("midreset zero",     {31'd0, zero},     32'd1);
        watch_no_valid("midreset no out_valid", 40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
